// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the byte-serial memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned RAM_RD_LAT = 1;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Any byte count other than 1 or 2 is serviced as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one 8-bit RAM port between instruction fetch and MEM,
//               sequencing accesses as little-endian byte transfers.
//               Optional macro MEM_ARBITER_RR_EN selects round-robin grants.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              flush_i,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic              busy_o
);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [2:0]        r_len, w_len_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [31:0]       r_asm, w_asm_nxt;
    logic              r_sel_mem, w_sel_mem_nxt;

    logic              r_if_done, w_if_done_nxt;
    logic [31:0]       r_if_data, w_if_data_nxt;
    logic              r_mem_done, w_mem_done_nxt;
    logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic              r_ram_we, w_ram_we_nxt;
    logic [7:0]        r_ram_dout, w_ram_dout_nxt;
    logic              r_busy, w_busy_nxt;

    logic [2:0]        w_cnt_inc;
    logic [2:0]        w_lane;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [31:0]       w_cap;
    logic [7:0]        w_wbyte;
    logic              w_grant_mem;

    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_addr_inc = r_base + ADDR_W'(w_cnt_inc);
    // Byte on ram_din_i belongs to the address issued RAM_RD_LAT cycles ago.
    assign w_lane     = r_cnt - 3'(RAM_RD_LAT);
    assign w_wbyte    = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];

    always_comb begin
        w_cap = r_asm;
        w_cap[{w_lane[1:0], 3'b000} +: 8] = ram_din_i;
    end

`ifdef MEM_ARBITER_RR_EN
    logic r_last_mem, w_last_mem_nxt;

    assign w_grant_mem = mem_req_i & (~if_req_i | ~r_last_mem);

    always_comb begin
        w_last_mem_nxt = r_last_mem;
        if (r_state == IDLE) begin
            if (w_grant_mem) begin
                w_last_mem_nxt = 1'b1;
            end else if (if_req_i) begin
                w_last_mem_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_mem <= 1'b0;
        end else begin
            r_last_mem <= w_last_mem_nxt;
        end
    end
`else
    assign w_grant_mem = mem_req_i;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_len_nxt       = r_len;
        w_base_nxt      = r_base;
        w_wdata_nxt     = r_wdata;
        w_asm_nxt       = r_asm;
        w_sel_mem_nxt   = r_sel_mem;
        w_if_done_nxt   = 1'b0;
        w_if_data_nxt   = 32'd0;
        w_mem_done_nxt  = 1'b0;
        w_mem_rdata_nxt = 32'd0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_we_nxt    = 1'b0;
        w_ram_dout_nxt  = r_ram_dout;

        case (r_state)
            IDLE: begin
                if (w_grant_mem) begin
                    w_sel_mem_nxt  = 1'b1;
                    w_base_nxt     = mem_addr_i;
                    w_len_nxt      = norm_len(mem_len_i);
                    w_wdata_nxt    = mem_wdata_i;
                    w_asm_nxt      = 32'd0;
                    w_cnt_nxt      = 3'd0;
                    w_ram_addr_nxt = mem_addr_i;
                    if (mem_we_i) begin
                        w_state_nxt    = MEM_WR;
                        w_ram_we_nxt   = 1'b1;
                        w_ram_dout_nxt = mem_wdata_i[7:0];
                    end else begin
                        w_state_nxt    = MEM_RD;
                    end
                end else if (if_req_i) begin
                    w_sel_mem_nxt  = 1'b0;
                    w_base_nxt     = if_addr_i;
                    w_len_nxt      = LEN_W;
                    w_asm_nxt      = 32'd0;
                    w_cnt_nxt      = 3'd0;
                    w_ram_addr_nxt = if_addr_i;
                    w_state_nxt    = IF_RD;
                end
            end

            IF_RD, MEM_RD: begin
                if ((r_state == IF_RD) && flush_i) begin
                    w_state_nxt = IDLE;
                    w_asm_nxt   = 32'd0;
                end else begin
                    if (r_cnt >= 3'(RAM_RD_LAT)) begin
                        w_asm_nxt = w_cap;
                    end
                    if (r_cnt == r_len) begin
                        w_state_nxt = DONE;
                        if (r_sel_mem) begin
                            w_mem_done_nxt  = 1'b1;
                            w_mem_rdata_nxt = w_cap;
                        end else begin
                            w_if_done_nxt   = 1'b1;
                            w_if_data_nxt   = w_cap;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc != r_len) begin
                            w_ram_addr_nxt = w_addr_inc;
                        end
                    end
                end
            end

            MEM_WR: begin
                if (r_cnt == (r_len - 3'd1)) begin
                    w_state_nxt    = DONE;
                    w_mem_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_ram_we_nxt   = 1'b1;
                    w_ram_addr_nxt = w_addr_inc;
                    w_ram_dout_nxt = w_wbyte;
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_base      <= '0;
            r_wdata     <= 32'd0;
            r_asm       <= 32'd0;
            r_sel_mem   <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= 32'd0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= 32'd0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_dout  <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_len       <= w_len_nxt;
            r_base      <= w_base_nxt;
            r_wdata     <= w_wdata_nxt;
            r_asm       <= w_asm_nxt;
            r_sel_mem   <= w_sel_mem_nxt;
            r_if_done   <= w_if_done_nxt;
            r_if_data   <= w_if_data_nxt;
            r_mem_done  <= w_mem_done_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_dout  <= w_ram_dout_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign if_done_o   = r_if_done;
    assign if_data_o   = r_if_data;
    assign mem_done_o  = r_mem_done;
    assign mem_rdata_o = r_mem_rdata;
    assign ram_addr_o  = r_ram_addr;
    assign ram_we_o    = r_ram_we;
    assign ram_dout_o  = r_ram_dout;
    assign busy_o      = r_busy;

endmodule : mem_arbiter
`default_nettype wire
